bmp_stream_writer: RTL and testbench

Streaming BMP encoder that replaces the testbench-only frame-memory writer. It accepts `PIX_PER_CLK` RGB888 pixels per beat over a valid/ready handshake and emits a complete 24-bit BMP byte stream: a 54-byte header generated from the parameters, then pixel bytes with 4-byte row padding. It sits at the end of the processing pipeline and feeds a byte sink (file writer in simulation, UART/DMA in hardware). No frame buffer is used; rows leave in arrival order.

---
 rtl/bmp_stream_writer.sv | 256 +++++++++++++++++++++++++
 tb/tb_bmp_stream_writer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: streams a 24-bit BMP file (54-byte header, then pixel rows
// with 4-byte row padding) from a valid/ready pixel-beat input, without a frame buffer.
module bmp_stream_writer #(
    parameter int unsigned WIDTH       = 768,
    parameter int unsigned HEIGHT      = 512,
    parameter int unsigned PIX_PER_CLK = 2,
    parameter bit          TOP_DOWN    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*PIX_PER_CLK-1:0] in_r,
    input  logic [8*PIX_PER_CLK-1:0] in_g,
    input  logic [8*PIX_PER_CLK-1:0] in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_byte,
    output logic                     out_last,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned ROW_BYTES     = 3 * WIDTH;
    localparam int unsigned PAD_BYTES     = (4 - (ROW_BYTES % 4)) % 4;
    localparam int unsigned IMG_BYTES     = (ROW_BYTES + PAD_BYTES) * HEIGHT;
    localparam int unsigned FILE_BYTES    = 54 + IMG_BYTES;
    localparam int unsigned LANE_BYTES    = 3 * PIX_PER_CLK;
    localparam int unsigned BEATS_PER_ROW = WIDTH / PIX_PER_CLK;
    localparam int unsigned TOTAL_BEATS   = BEATS_PER_ROW * HEIGHT;
    localparam bit          HAS_PAD       = (PAD_BYTES != 0);

    localparam int LANE_W  = $clog2(LANE_BYTES);
    localparam int LANE_SLOTS = 1 << LANE_W;
    localparam int COL_W   = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BEAT_W  = $clog2(TOTAL_BEATS + 1);

    localparam logic [31:0] HDR_FSIZE  = 32'(FILE_BYTES);
    localparam logic [31:0] HDR_IMG    = 32'(IMG_BYTES);
    localparam logic [31:0] HDR_WIDTH  = 32'(WIDTH);
    localparam logic [31:0] HDR_HEIGHT = TOP_DOWN ? (32'd0 - 32'(HEIGHT)) : 32'(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PIXEL,
        S_PAD,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [5:0]              r_hdrIdx;
    logic [LANE_W-1:0]       r_lane;
    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic [1:0]              r_pad;
    logic [BEAT_W-1:0]       r_beats;
    logic                    r_holdFull;
    logic [8*PIX_PER_CLK-1:0] r_holdR;
    logic [8*PIX_PER_CLK-1:0] r_holdG;
    logic [8*PIX_PER_CLK-1:0] r_holdB;

    logic       w_lastHdr;
    logic       w_lastLane;
    logic       w_lastCol;
    logic       w_lastRow;
    logic       w_lastPad;
    logic       w_xfer;
    logic       w_pixDone;
    logic       w_inFire;
    logic [7:0] w_beatBytes [LANE_SLOTS];

    // Fixed header contents; every field not listed is zero.
    function automatic logic [7:0] headerByte(input logic [5:0] idx);
        case (idx)
            6'd0:    return 8'h42;
            6'd1:    return 8'h4D;
            6'd2:    return HDR_FSIZE[7:0];
            6'd3:    return HDR_FSIZE[15:8];
            6'd4:    return HDR_FSIZE[23:16];
            6'd5:    return HDR_FSIZE[31:24];
            6'd10:   return 8'd54;
            6'd14:   return 8'd40;
            6'd18:   return HDR_WIDTH[7:0];
            6'd19:   return HDR_WIDTH[15:8];
            6'd20:   return HDR_WIDTH[23:16];
            6'd21:   return HDR_WIDTH[31:24];
            6'd22:   return HDR_HEIGHT[7:0];
            6'd23:   return HDR_HEIGHT[15:8];
            6'd24:   return HDR_HEIGHT[23:16];
            6'd25:   return HDR_HEIGHT[31:24];
            6'd26:   return 8'd1;
            6'd28:   return 8'd24;
            6'd34:   return HDR_IMG[7:0];
            6'd35:   return HDR_IMG[15:8];
            6'd36:   return HDR_IMG[23:16];
            6'd37:   return HDR_IMG[31:24];
            default: return 8'h00;
        endcase
    endfunction

    assign w_lastHdr  = (r_hdrIdx == 6'd53);
    assign w_lastLane = (r_lane == LANE_W'(LANE_BYTES - 1));
    assign w_lastCol  = (r_col == COL_W'(BEATS_PER_ROW - 1));
    assign w_lastRow  = (r_row == ROW_W'(HEIGHT - 1));
    assign w_lastPad  = (r_pad == 2'(PAD_BYTES - 1));
    assign w_xfer     = out_valid & out_ready;
    assign w_pixDone  = (r_state == S_PIXEL) & w_xfer & w_lastLane;
    // Ready looks at the post-transfer empty flag so the hold register can refill back to back.
    assign in_ready   = busy & (~r_holdFull | w_pixDone) & (r_beats < BEAT_W'(TOTAL_BEATS));
    assign w_inFire   = in_valid & in_ready;

    // Flatten the held beat into byte order B,G,R per pixel, leftmost pixel first.
    always_comb begin
        for (int i = 0; i < LANE_SLOTS; i++) begin
            w_beatBytes[i] = 8'h00;
        end
        for (int p = 0; p < int'(PIX_PER_CLK); p++) begin
            w_beatBytes[3*p]     = r_holdB[8*p +: 8];
            w_beatBytes[3*p + 1] = r_holdG[8*p +: 8];
            w_beatBytes[3*p + 2] = r_holdR[8*p +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode and stream outputs for the current phase.
    always_comb begin
        w_stateNext = r_state;
        out_valid   = 1'b0;
        out_byte    = 8'h00;
        out_last    = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext = S_HEADER;
                end
            end
            S_HEADER: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_byte  = headerByte(r_hdrIdx);
                if (out_ready && w_lastHdr) begin
                    w_stateNext = S_PIXEL;
                end
            end
            S_PIXEL: begin
                busy      = 1'b1;
                out_valid = r_holdFull;
                out_byte  = w_beatBytes[r_lane];
                out_last  = !HAS_PAD && w_lastRow && w_lastCol && w_lastLane;
                if (r_holdFull && out_ready && w_lastLane && w_lastCol) begin
                    if (HAS_PAD) begin
                        w_stateNext = S_PAD;
                    end else if (w_lastRow) begin
                        w_stateNext = S_DONE;
                    end
                end
            end
            S_PAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = w_lastRow && w_lastPad;
                if (out_ready && w_lastPad) begin
                    w_stateNext = w_lastRow ? S_DONE : S_PIXEL;
                end
            end
            S_DONE: begin
                frame_done  = 1'b1;
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Position counters and the one-beat input holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdrIdx   <= '0;
            r_lane     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_pad      <= '0;
            r_beats    <= '0;
            r_holdFull <= 1'b0;
            r_holdR    <= '0;
            r_holdG    <= '0;
            r_holdB    <= '0;
        end else begin
            if (w_inFire) begin
                r_holdFull <= 1'b1;
                r_holdR    <= in_r;
                r_holdG    <= in_g;
                r_holdB    <= in_b;
                r_beats    <= r_beats + 1'b1;
            end else if (w_pixDone) begin
                r_holdFull <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hdrIdx   <= '0;
                        r_lane     <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_pad      <= '0;
                        r_beats    <= '0;
                        r_holdFull <= 1'b0;
                    end
                end
                S_HEADER: begin
                    if (w_xfer) begin
                        r_hdrIdx <= w_lastHdr ? 6'd0 : r_hdrIdx + 6'd1;
                    end
                end
                S_PIXEL: begin
                    if (w_xfer) begin
                        r_lane <= w_lastLane ? '0 : r_lane + 1'b1;
                        if (w_lastLane) begin
                            r_col <= w_lastCol ? '0 : r_col + 1'b1;
                            if (w_lastCol && !HAS_PAD && !w_lastRow) begin
                                r_row <= r_row + 1'b1;
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (w_xfer) begin
                        r_pad <= w_lastPad ? 2'd0 : r_pad + 2'd1;
                        if (w_lastPad && !w_lastRow) begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Testbench for bmp_stream_writer: two small instances (4x2 x2 lanes top-down,
// 5x2 x1 lane bottom-up with padding) driven with ideal, stalled and aborted frames.
module tb_bmp_stream_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   sel = 0;

    logic        start    = 1'b0;
    logic        inValid  = 1'b0;
    logic        outReady = 1'b0;
    logic [15:0] inR = '0, inG = '0, inB = '0;

    logic       inReadyA, outValidA, outLastA, busyA, frameDoneA;
    logic [7:0] outByteA;
    logic       inReadyB, outValidB, outLastB, busyB, frameDoneB;
    logic [7:0] outByteB;

    logic       inReady, outValid, outLast, busy, frameDone;
    logic [7:0] outByte;

    int checks   = 0;
    int failures = 0;

    int          totalBeats;
    logic [15:0] beatR[$], beatG[$], beatB[$];
    logic [7:0]  expBytes[$];
    logic [7:0]  gotBytes[$];

    always #5 clk = ~clk;

    bmp_stream_writer #(.WIDTH(4), .HEIGHT(2), .PIX_PER_CLK(2), .TOP_DOWN(1'b1)) dutA (
        .clk(clk), .rst(rst), .start(start && sel == 0), .in_valid(inValid && sel == 0),
        .in_ready(inReadyA), .in_r(inR), .in_g(inG), .in_b(inB),
        .out_valid(outValidA), .out_ready(outReady), .out_byte(outByteA),
        .out_last(outLastA), .busy(busyA), .frame_done(frameDoneA)
    );

    bmp_stream_writer #(.WIDTH(5), .HEIGHT(2), .PIX_PER_CLK(1), .TOP_DOWN(1'b0)) dutB (
        .clk(clk), .rst(rst), .start(start && sel == 1), .in_valid(inValid && sel == 1),
        .in_ready(inReadyB), .in_r(inR[7:0]), .in_g(inG[7:0]), .in_b(inB[7:0]),
        .out_valid(outValidB), .out_ready(outReady), .out_byte(outByteB),
        .out_last(outLastB), .busy(busyB), .frame_done(frameDoneB)
    );

    // Route the selected instance's outputs onto a common set of probes.
    always_comb begin
        inReady   = (sel == 0) ? inReadyA   : inReadyB;
        outValid  = (sel == 0) ? outValidA  : outValidB;
        outByte   = (sel == 0) ? outByteA   : outByteB;
        outLast   = (sel == 0) ? outLastA   : outLastB;
        busy      = (sel == 0) ? busyA      : busyB;
        frameDone = (sel == 0) ? frameDoneA : frameDoneB;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit iv, input bit ordy,
                                 input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
        @(posedge clk);
        #1;
        start    = st;
        inValid  = iv;
        outReady = ordy;
        inR      = r;
        inG      = g;
        inB      = b;
    endtask

    // Hand-computed headers plus fresh pixel data for the selected instance.
    task automatic buildExpected();
        logic [7:0] hdr [54];
        int width, height, ppc, pad, bpr;
        beatR.delete(); beatG.delete(); beatB.delete(); expBytes.delete();
        for (int i = 0; i < 54; i++) hdr[i] = 8'h00;
        hdr[0] = 8'h42; hdr[1] = 8'h4D; hdr[10] = 8'h36; hdr[14] = 8'h28;
        hdr[26] = 8'h01; hdr[28] = 8'h18;
        if (sel == 0) begin
            width = 4; height = 2; ppc = 2; pad = 0;
            hdr[2] = 8'h4E; hdr[18] = 8'h04;
            hdr[22] = 8'hFE; hdr[23] = 8'hFF; hdr[24] = 8'hFF; hdr[25] = 8'hFF;
            hdr[34] = 8'h18;
        end else begin
            width = 5; height = 2; ppc = 1; pad = 1;
            hdr[2] = 8'h56; hdr[18] = 8'h05; hdr[22] = 8'h02; hdr[34] = 8'h20;
        end
        bpr = width / ppc;
        totalBeats = bpr * height;
        for (int i = 0; i < 54; i++) expBytes.push_back(hdr[i]);
        for (int k = 0; k < totalBeats; k++) begin
            if (sel == 0 && k == 0) begin
                beatR.push_back(16'h2211); beatG.push_back(16'h4433); beatB.push_back(16'h6655);
            end else begin
                beatR.push_back(16'($urandom)); beatG.push_back(16'($urandom));
                beatB.push_back(16'($urandom));
            end
        end
        for (int row = 0; row < height; row++) begin
            for (int c = 0; c < bpr; c++) begin
                for (int p = 0; p < ppc; p++) begin
                    expBytes.push_back(beatB[row*bpr + c][8*p +: 8]);
                    expBytes.push_back(beatG[row*bpr + c][8*p +: 8]);
                    expBytes.push_back(beatR[row*bpr + c][8*p +: 8]);
                end
            end
            for (int q = 0; q < pad; q++) expBytes.push_back(8'h00);
        end
    endtask

    // Run one frame on the selected instance; abortAt >= 0 resets mid-stream after that many bytes.
    task automatic runFrame(input bit randomMode, input int abortAt);
        int got = 0, beatIdx = 0, lastXferCyc = -1, doneCount = 0, doneCyc = 0;
        int stallErr = 0, extraBeat = 0;
        bit prevStall = 0, aborted = 0, st, iv, ordy;
        logic [7:0] prevByte = 8'h00;
        logic prevLast = 1'b0;
        logic [15:0] r, g, b;
        gotBytes.delete();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            st   = randomMode && doneCount == 0 && ($urandom_range(0, 9) == 0);
            iv   = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
            ordy = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (beatIdx < totalBeats) begin
                r = beatR[beatIdx]; g = beatG[beatIdx]; b = beatB[beatIdx];
            end else begin
                r = 16'($urandom); g = 16'($urandom); b = 16'($urandom);
            end
            applyStimulus(st, iv, ordy, r, g, b);
            @(negedge clk);
            if (cyc == 0) checkOutput("firstByte", {busy, outValid, outByte}, {1'b1, 1'b1, 8'h42});
            if (prevStall && (!outValid || outByte !== prevByte || outLast !== prevLast)) stallErr++;
            prevStall = outValid && !outReady;
            prevByte  = outByte;
            prevLast  = outLast;
            if (inValid && inReady) begin
                if (beatIdx >= totalBeats) extraBeat++;
                else beatIdx++;
            end
            if (outValid && outReady) begin
                if (got < expBytes.size()) begin
                    checkOutput($sformatf("byte%0d", got), outByte, expBytes[got]);
                    if (outLast || got == expBytes.size() - 1)
                        checkOutput($sformatf("last%0d", got), outLast, got == expBytes.size() - 1);
                end else begin
                    checkOutput("extraByte", got, expBytes.size());
                end
                gotBytes.push_back(outByte);
                got++;
                lastXferCyc = cyc;
            end
            if (frameDone) begin
                doneCount++;
                if (doneCount == 1) begin
                    doneCyc = cyc;
                    checkOutput("doneTiming", cyc, lastXferCyc + 1);
                    checkOutput("busyAtDone", busy, 1'b0);
                end
            end
            if (abortAt >= 0 && got == abortAt) begin
                aborted = 1;
                break;
            end
            if (doneCount > 0 && cyc >= doneCyc + 2) break;
        end
        if (aborted) begin
            @(posedge clk);
            #1 rst = 1'b1;
            #1 checkOutput("rstOutputs", {inReady, outValid, outByte, outLast, busy, frameDone}, 13'h0);
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        checkOutput("byteCount", got, expBytes.size());
        checkOutput("doneCount", doneCount, 1);
        checkOutput("stallStable", stallErr, 0);
        checkOutput("extraBeat", extraBeat, 0);
        checkOutput("beatCount", beatIdx, totalBeats);
        if (sel == 0 && got >= 60)
            checkOutput("laneOrder", {gotBytes[54], gotBytes[55], gotBytes[56],
                                      gotBytes[57], gotBytes[58], gotBytes[59]}, 48'h553311664422);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetA", {inReadyA, outValidA, outByteA, outLastA, busyA, frameDoneA}, 13'h0);
        checkOutput("resetB", {inReadyB, outValidB, outByteB, outLastB, busyB, frameDoneB}, 13'h0);
        @(negedge clk);
        rst = 1'b0;

        sel = 0; buildExpected(); runFrame(1'b0, -1);
        sel = 0; buildExpected(); runFrame(1'b1, -1);
        sel = 1; buildExpected(); runFrame(1'b0, -1);
        sel = 1; buildExpected(); runFrame(1'b1, -1);
        sel = 0; buildExpected(); runFrame(1'b0, 70);
        sel = 0; buildExpected(); runFrame(1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
